// File: rtl/wb_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_slot_arbiter
// Description : Arbitrates the MEM/WB writeback slot between the M-stage
//               instruction and results queued from the iterative divider.
//               Optional statistics counters are built when the macro
//               WB_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slot_arbiter #(
    parameter int DIV_FIFO_DEPTH = 2,
    parameter int MAX_DEFER      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    input  logic [4:0]  m_rd,
    input  logic        div_done,
    input  logic [4:0]  div_rd,
    input  logic [31:0] div_result,
    input  logic [31:0] div_pc,
    input  logic [31:0] div_inst,
    output logic        div_ready,
    output logic        grant_m,
    output logic        grant_div,
    output logic        stall_m,
    output logic [4:0]  wb_div_rd,
    output logic [31:0] wb_div_result,
    output logic [31:0] wb_div_pc,
    output logic [31:0] wb_div_inst,
    output logic [31:0] div_pending_mask,
    output logic        overflow,
    output logic [15:0] stat_stall_cycles,
    output logic [15:0] stat_forced
);

    localparam int c_ptr_w = (DIV_FIFO_DEPTH > 2) ? 2 : 1;
    localparam int c_cnt_w = (DIV_FIFO_DEPTH > 3) ? 3 : 2;

    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(DIV_FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(DIV_FIFO_DEPTH - 1);
    localparam logic [2:0]         c_max_defer = 3'(MAX_DEFER);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FORCE   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [2:0]                r_defer;
    logic [2:0]                w_defer_next;
    logic [c_cnt_w-1:0]        r_count;
    logic [c_cnt_w-1:0]        w_count_next;
    logic [c_ptr_w-1:0]        r_wr_ptr;
    logic [c_ptr_w-1:0]        r_rd_ptr;
    logic [DIV_FIFO_DEPTH-1:0] r_slot_vld;
    logic [DIV_FIFO_DEPTH-1:0] w_slot_vld_next;
    logic [31:0]               r_pending_mask;
    logic [31:0]               w_mask_next;
    logic                      r_overflow;

    logic [4:0]  r_rd_mem     [DIV_FIFO_DEPTH];
    logic [31:0] r_result_mem [DIV_FIFO_DEPTH];
    logic [31:0] r_pc_mem     [DIV_FIFO_DEPTH];
    logic [31:0] r_inst_mem   [DIV_FIFO_DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_waw;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign div_ready = ~w_full;
    assign w_push    = div_done & ~w_full;
    assign w_pop     = grant_div;
    // The pending mask never has bit 0 set, so x0 can never look like a hazard.
    assign w_waw     = (m_rd != 5'd0) & r_pending_mask[m_rd];

    assign div_pending_mask = r_pending_mask;
    assign overflow         = r_overflow;

    always_comb begin
        grant_m      = 1'b0;
        grant_div    = 1'b0;
        stall_m      = 1'b0;
        w_defer_next = r_defer;
        w_count_next = r_count;
        w_state_next = r_state;

        if (rst_n) begin
            if (w_empty) begin
                grant_m = m_valid;
            end else if (!m_valid) begin
                grant_div = 1'b1;
            end else if (w_full || (r_state == FORCE) || w_waw) begin
                grant_div = 1'b1;
                stall_m   = 1'b1;
            end else begin
                grant_m = 1'b1;
            end
        end

        if (w_empty || grant_div) begin
            w_defer_next = 3'd0;
        end else if (r_defer < c_max_defer) begin
            w_defer_next = r_defer + 3'd1;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase

        if (w_count_next == '0) begin
            w_state_next = IDLE;
        end else if (w_defer_next == c_max_defer) begin
            w_state_next = FORCE;
        end else begin
            w_state_next = PENDING;
        end
    end

    // Mask is rebuilt from post-edge occupancy so it tracks push/pop exactly.
    always_comb begin
        w_slot_vld_next = r_slot_vld;
        if (w_pop) begin
            w_slot_vld_next[r_rd_ptr] = 1'b0;
        end
        if (w_push) begin
            w_slot_vld_next[r_wr_ptr] = 1'b1;
        end
        w_mask_next = '0;
        for (int i = 0; i < DIV_FIFO_DEPTH; i++) begin
            if (w_slot_vld_next[i]) begin
                if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
                    w_mask_next[div_rd] = 1'b1;
                end else begin
                    w_mask_next[r_rd_mem[i]] = 1'b1;
                end
            end
        end
        w_mask_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_defer        <= 3'd0;
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_slot_vld     <= '0;
            r_pending_mask <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_defer        <= w_defer_next;
            r_count        <= w_count_next;
            r_slot_vld     <= w_slot_vld_next;
            r_pending_mask <= w_mask_next;
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (div_done && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: slot valid bits gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wr_ptr]     <= div_rd;
            r_result_mem[r_wr_ptr] <= div_result;
            r_pc_mem[r_wr_ptr]     <= div_pc;
            r_inst_mem[r_wr_ptr]   <= div_inst;
        end
    end

    always_comb begin
        wb_div_rd     = 5'd0;
        wb_div_result = 32'd0;
        wb_div_pc     = 32'd0;
        wb_div_inst   = 32'd0;
        if (rst_n && !w_empty) begin
            wb_div_rd     = r_rd_mem[r_rd_ptr];
            wb_div_result = r_result_mem[r_rd_ptr];
            wb_div_pc     = r_pc_mem[r_rd_ptr];
            wb_div_inst   = r_inst_mem[r_rd_ptr];
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_forced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_stall  <= 16'd0;
            r_stat_forced <= 16'd0;
        end else begin
            if (stall_m && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if ((r_state == FORCE) && grant_div && (r_stat_forced != 16'hFFFF)) begin
                r_stat_forced <= r_stat_forced + 16'd1;
            end
        end
    end

    assign stat_stall_cycles = r_stat_stall;
    assign stat_forced       = r_stat_forced;
`else
    assign stat_stall_cycles = 16'd0;
    assign stat_forced       = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_slot_arbiter
// Description : Directed self-checking bench for wb_slot_arbiter (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_slot_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic [4:0]  m_rd;
    logic        div_done;
    logic [4:0]  div_rd;
    logic [31:0] div_result;
    logic [31:0] div_pc;
    logic [31:0] div_inst;
    logic        div_ready;
    logic        grant_m;
    logic        grant_div;
    logic        stall_m;
    logic [4:0]  wb_div_rd;
    logic [31:0] wb_div_result;
    logic [31:0] wb_div_pc;
    logic [31:0] wb_div_inst;
    logic [31:0] div_pending_mask;
    logic        overflow;
    logic [15:0] stat_stall_cycles;
    logic [15:0] stat_forced;

    int n_total = 0;
    int n_bad   = 0;

    wb_slot_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .m_valid           (m_valid),
        .m_rd              (m_rd),
        .div_done          (div_done),
        .div_rd            (div_rd),
        .div_result        (div_result),
        .div_pc            (div_pc),
        .div_inst          (div_inst),
        .div_ready         (div_ready),
        .grant_m           (grant_m),
        .grant_div         (grant_div),
        .stall_m           (stall_m),
        .wb_div_rd         (wb_div_rd),
        .wb_div_result     (wb_div_result),
        .wb_div_pc         (wb_div_pc),
        .wb_div_inst       (wb_div_inst),
        .div_pending_mask  (div_pending_mask),
        .overflow          (overflow),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_forced       (stat_forced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected value packed as {grant_m, grant_div, stall_m}.
    task automatic chk_g(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, grant_m, grant_div, stall_m}, {29'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_div(input logic done, input logic [4:0] rd, input logic [31:0] res);
        div_done   = done;
        div_rd     = rd;
        div_result = res;
        div_pc     = res + 32'h1000;
        div_inst   = ~res;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_valid = 1'b1;
        m_rd    = 5'd7;
        drive_div(1'b0, 5'd0, 32'd0);
        #2;
        chk_g("reset_grants", 3'b000);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_mask", div_pending_mask, 32'd0);
        chk("reset_wb_result", wb_div_result, 32'd0);
        chk("reset_ready", {31'd0, div_ready}, 32'd1);
        tick();
        tick();
        rst_n   = 1'b1;
        m_valid = 1'b0;

        // Single divider result with M idle
        drive_div(1'b1, 5'd5, 32'h2A);
        #1;
        chk_g("t1_no_bypass", 3'b000);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        #1;
        chk_g("t1_grant_div", 3'b010);
        chk("t1_wb_result", wb_div_result, 32'h2A);
        chk("t1_wb_rd", {27'd0, wb_div_rd}, 32'd5);
        chk("t1_wb_pc", wb_div_pc, 32'h102A);
        chk("t1_mask_set", div_pending_mask, 32'h20);
        tick();
        #1;
        chk_g("t1_after_pop", 3'b000);
        chk("t1_mask_clr", div_pending_mask, 32'd0);
        chk("t1_count", 32'(dut.r_count), 32'd0);

        // Divider entry yields to M for MAX_DEFER cycles, then is forced
        m_valid = 1'b1;
        m_rd    = 5'd7;
        drive_div(1'b1, 5'd5, 32'h11);
        #1;
        chk_g("t2_push_cycle", 3'b100);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk_g($sformatf("t2_defer%0d", k), 3'b100);
            tick();
        end
        #1;
        chk_g("t2_forced", 3'b011);
        chk("t2_force_state", 32'(dut.r_state), 32'd2);
        chk("t2_wb_result", wb_div_result, 32'h11);
        tick();
        #1;
        chk_g("t2_resume", 3'b100);
        chk("t2_count", 32'(dut.r_count), 32'd0);

        // WAW hazard on rd=9
        m_valid = 1'b0;
        drive_div(1'b1, 5'd9, 32'h99);
        #1;
        chk_g("t3_push_cycle", 3'b000);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        m_valid = 1'b1;
        m_rd    = 5'd9;
        #1;
        chk_g("t3_waw_stall", 3'b011);
        chk("t3_wb_rd", {27'd0, wb_div_rd}, 32'd9);
        tick();
        #1;
        chk_g("t3_resume", 3'b100);

        // rd=0 entry never creates a hazard or a mask bit
        m_valid = 1'b0;
        drive_div(1'b1, 5'd0, 32'h55);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        m_valid = 1'b1;
        m_rd    = 5'd0;
        #1;
        chk_g("t3b_x0_no_waw", 3'b100);
        chk("t3b_mask_x0", div_pending_mask, 32'd0);
        tick();
        m_valid = 1'b0;
        #1;
        chk_g("t3b_drain", 3'b010);
        chk("t3b_wb_result", wb_div_result, 32'h55);
        tick();
        #1;
        chk("t3b_count", 32'(dut.r_count), 32'd0);

        // Fill to full, then overflow
        m_valid = 1'b1;
        m_rd    = 5'd7;
        drive_div(1'b1, 5'd3, 32'hA1);
        #1;
        chk_g("t4_fill0", 3'b100);
        tick();
        drive_div(1'b1, 5'd4, 32'hA2);
        #1;
        chk_g("t4_fill1", 3'b100);
        chk("t4_mask1", div_pending_mask, 32'h08);
        tick();
        drive_div(1'b1, 5'd6, 32'hA3);
        #1;
        chk("t4_ready_full", {31'd0, div_ready}, 32'd0);
        chk_g("t4_full_forced", 3'b011);
        chk("t4_count_full", 32'(dut.r_count), 32'd2);
        chk("t4_mask_full", div_pending_mask, 32'h18);
        chk("t4_wb_head", wb_div_result, 32'hA1);
        chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        #1;
        chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
        chk("t4_count_after", 32'(dut.r_count), 32'd1);
        chk("t4_mask_after", div_pending_mask, 32'h10);
        chk("t4_wb_next", wb_div_result, 32'hA2);
        chk_g("t4_m_after", 3'b100);
        tick();
        m_valid = 1'b0;
        #1;
        chk_g("t4_drain", 3'b010);
        tick();
        #1;
        chk("t4_count_empty", 32'(dut.r_count), 32'd0);
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Simultaneous push/pop at count=1 across pointer wrap
        drive_div(1'b1, 5'd1, 32'h100);
        #1;
        chk_g("t5_prime", 3'b000);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive_div(1'b1, 5'((k + 1) % 31 + 1), 32'h101 + 32'(k));
            #1;
            chk_g($sformatf("t5_grant%0d", k), 3'b010);
            chk($sformatf("t5_result%0d", k), wb_div_result, 32'h100 + 32'(k));
            chk($sformatf("t5_rd%0d", k), {27'd0, wb_div_rd}, 32'(k % 31 + 1));
            chk($sformatf("t5_mask%0d", k), div_pending_mask, 32'd1 << (k % 31 + 1));
            chk($sformatf("t5_count%0d", k), 32'(dut.r_count), 32'd1);
            tick();
        end
        drive_div(1'b0, 5'd0, 32'd0);
        #1;
        chk("t5_last", wb_div_result, 32'h10A);
        chk_g("t5_last_grant", 3'b010);
        tick();
        #1;
        chk("t5_count_end", 32'(dut.r_count), 32'd0);

        // Asynchronous reset with two entries pending
        m_valid = 1'b1;
        m_rd    = 5'd7;
        drive_div(1'b1, 5'd12, 32'hC1);
        tick();
        drive_div(1'b1, 5'd13, 32'hC2);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        #1;
        chk_g("t6_full_forced", 3'b011);
        chk("t6_mask_full", div_pending_mask, 32'h3000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_g("t6_async_grants", 3'b000);
        chk("t6_async_mask", div_pending_mask, 32'd0);
        chk("t6_async_wb", wb_div_result, 32'd0);
        chk("t6_async_count", 32'(dut.r_count), 32'd0);
        chk("t6_async_ovf", {31'd0, overflow}, 32'd0);
        chk("t6_async_ready", {31'd0, div_ready}, 32'd1);
        tick();
        rst_n   = 1'b1;
        m_valid = 1'b0;
        drive_div(1'b1, 5'd8, 32'hBEEF);
        #1;
        chk_g("t6_post_push", 3'b000);
        tick();
        drive_div(1'b0, 5'd0, 32'd0);
        #1;
        chk_g("t6_post_grant", 3'b010);
        chk("t6_post_wb", wb_div_result, 32'hBEEF);
        chk("t6_post_mask", div_pending_mask, 32'h100);
`ifndef WB_ARB_STATS_EN
        chk("stats_tied", {stat_stall_cycles, stat_forced}, 32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
